// File: rtl/lsu_pipelined.sv
// Pipelined load-store unit: issue handshake, DMEM request register, in-order load queue, registered writeback.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_pipelined #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4,
  parameter int RD_W     = 5
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_is_load,
  input  logic                         i_is_store,
  input  logic [2:0]                   i_funct3,
  input  logic [11:0]                  i_imm,
  input  logic [XLEN-1:0]              i_op0,
  input  logic [XLEN-1:0]              i_op1,
  input  logic [RD_W-1:0]              i_rd,
  output logic                         o_req_valid,
  input  logic                         i_req_ready,
  output logic                         o_req_cmd,
  output logic [XLEN-1:0]              o_req_addr,
  output logic [1:0]                   o_req_size,
  output logic [XLEN-1:0]              o_req_data,
  output logic [XLEN/8-1:0]            o_req_strb,
  input  logic                         i_rsp_valid,
  input  logic [XLEN-1:0]              i_rsp_data,
  output logic                         o_wb_valid,
  output logic [RD_W-1:0]              o_wb_rd,
  output logic [XLEN-1:0]              o_wb_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                         o_misalign,
  output logic [XLEN-1:0]              o_misalign_addr,
  output logic                         o_misalign_st,
`endif
  output logic [$clog2(LQ_DEPTH):0]    o_lq_cnt
);

  localparam int NB   = XLEN / 8;
  localparam int XLSB = $clog2(NB);
  localparam int PW   = $clog2(LQ_DEPTH);
  localparam int CW   = PW + 1;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            uns;
    logic [1:0]      sz;
    logic [XLSB-1:0] off;
    logic            kill;
  } lq_t;

  function automatic logic [XLEN-1:0] szmask(input logic [1:0] s);
    logic [XLEN-1:0] m;
    m = '1;
    unique case (s)
      2'b00: m = XLEN'(8'hFF);
      2'b01: m = XLEN'(16'hFFFF);
      2'b10: m = XLEN'(32'hFFFF_FFFF);
      default: m = '1;
    endcase
    return m;
  endfunction

  logic            req_valid_q, req_cmd_q, req_uns_q;
  logic [XLEN-1:0] req_addr_q, req_data_q;
  logic [1:0]      req_size_q;
  logic [NB-1:0]   req_strb_q;
  logic [RD_W-1:0] req_rd_q;

  lq_t             lq_q [LQ_DEPTH];
  logic [CW-1:0]   wp_q, rp_q, cnt;

  logic            wb_valid_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic [XLEN-1:0] addr, sdata, raw, rmask, rtop, wbd;
  logic [1:0]      sz;
  logic [XLSB-1:0] off;
  logic [NB-1:0]   bmask, strb;
  logic [CW:0]     occ;
  logic            rdy, acc, mem, issue, hs, alloc, pop, sbit;
  lq_t             head;

  assign cnt   = wp_q - rp_q;
  assign occ   = {1'b0, cnt} + (CW+1)'(req_valid_q && !req_cmd_q);
  assign rdy   = !i_flush && (!req_valid_q || i_req_ready)
                 && (occ < (CW+1)'(LQ_DEPTH));
  assign acc   = i_valid && rdy;
  assign mem   = acc && (i_is_load || i_is_store);
  assign hs    = req_valid_q && i_req_ready;
  assign alloc = hs && !req_cmd_q;
  assign pop   = i_rsp_valid && (cnt != '0);
  assign head  = lq_q[rp_q[PW-1:0]];

  always_comb begin
    addr  = i_op0 + {{(XLEN-12){i_imm[11]}}, i_imm};
    sz    = i_funct3[1:0];
    if (XLEN == 32 && sz == 2'b11) sz = 2'b10;
    off   = addr[XLSB-1:0];
    sdata = (i_op1 & szmask(sz)) << {off, 3'b000};
    bmask = '1;
    unique case (sz)
      2'b00: bmask = NB'(1);
      2'b01: bmask = NB'(3);
      2'b10: bmask = NB'(15);
      default: bmask = '1;
    endcase
    strb  = bmask << off;
  end

  // Load formatting: top bit of the size mask is the sign bit.
  always_comb begin
    raw   = i_rsp_data >> {head.off, 3'b000};
    rmask = szmask(head.sz);
    rtop  = rmask & ~(rmask >> 1);
    sbit  = !head.uns && |(raw & rtop);
    wbd   = (raw & rmask) | (sbit ? ~rmask : '0);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic [2:0]      lowm;
  logic            mis;
  logic            mis_q, mis_st_q;
  logic [XLEN-1:0] mis_addr_q;

  always_comb begin
    lowm = 3'b111;
    unique case (sz)
      2'b00: lowm = 3'b000;
      2'b01: lowm = 3'b001;
      2'b10: lowm = 3'b011;
      default: lowm = 3'b111;
    endcase
    mis = mem && |(addr[2:0] & lowm);
  end

  assign issue = mem && !mis;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mis_q      <= 1'b0;
      mis_st_q   <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q <= mis;
      if (mis) begin
        mis_addr_q <= addr;
        mis_st_q   <= i_is_store;
      end
    end
  end

  assign o_misalign      = mis_q;
  assign o_misalign_addr = mis_addr_q;
  assign o_misalign_st   = mis_st_q;
`else
  assign issue = mem;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      req_valid_q <= 1'b0;
      req_cmd_q   <= 1'b0;
      req_uns_q   <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_size_q  <= '0;
      req_strb_q  <= '0;
      req_rd_q    <= '0;
    end else if (issue) begin
      req_valid_q <= 1'b1;
      req_cmd_q   <= i_is_store;
      req_uns_q   <= i_funct3[2];
      req_addr_q  <= addr;
      req_data_q  <= sdata;
      req_size_q  <= sz;
      req_strb_q  <= strb;
      req_rd_q    <= i_rd;
    end else if (hs || i_flush) begin
      req_valid_q <= 1'b0;
    end
  end

  // A load handshaking during flush enters the queue already killed.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) lq_q[i] <= '0;
    end else begin
      if (i_flush)
        for (int i = 0; i < LQ_DEPTH; i++) lq_q[i].kill <= 1'b1;
      if (alloc) begin
        lq_q[wp_q[PW-1:0]] <= '{rd:   req_rd_q,
                                uns:  req_uns_q,
                                sz:   req_size_q,
                                off:  req_addr_q[XLSB-1:0],
                                kill: i_flush};
        wp_q <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= pop && !head.kill;
      if (pop) begin
        wb_rd_q   <= head.rd;
        wb_data_q <= wbd;
      end
    end
  end

  assign o_ready     = rdy;
  assign o_req_valid = req_valid_q;
  assign o_req_cmd   = req_cmd_q;
  assign o_req_addr  = req_addr_q;
  assign o_req_size  = req_size_q;
  assign o_req_data  = req_data_q;
  assign o_req_strb  = req_strb_q;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_rd     = wb_rd_q;
  assign o_wb_data   = wb_data_q;
  assign o_lq_cnt    = cnt;

endmodule

// File: tb/tb_lsu_pipelined.sv
// Directed bench for lsu_pipelined (XLEN=32, LQ_DEPTH=4).
// Inputs change and outputs are sampled just after the falling edge.
module tb_lsu_pipelined;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        i_flush, i_valid, i_is_load, i_is_store;
  logic [2:0]  i_funct3;
  logic [11:0] i_imm;
  logic [31:0] i_op0, i_op1, i_rsp_data;
  logic [4:0]  i_rd;
  logic        i_req_ready, i_rsp_valid;
  logic        o_ready, o_req_valid, o_req_cmd, o_wb_valid;
  logic [31:0] o_req_addr, o_req_data, o_wb_data;
  logic [1:0]  o_req_size;
  logic [3:0]  o_req_strb;
  logic [4:0]  o_wb_rd;
  logic [2:0]  o_lq_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        o_misalign, o_misalign_st;
  logic [31:0] o_misalign_addr;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_pipelined #(.XLEN(32), .LQ_DEPTH(4), .RD_W(5)) dut (
    .clk(clk), .aresetn(aresetn), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_funct3(i_funct3), .i_imm(i_imm),
    .i_op0(i_op0), .i_op1(i_op1), .i_rd(i_rd),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_cmd(o_req_cmd), .o_req_addr(o_req_addr),
    .o_req_size(o_req_size), .o_req_data(o_req_data),
    .o_req_strb(o_req_strb),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
`ifdef LSU_MISALIGN_TRAP_EN
    .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr),
    .o_misalign_st(o_misalign_st),
`endif
    .o_lq_cnt(o_lq_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
  endtask

  task automatic drv(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] b, input logic [11:0] imm,
                     input logic [31:0] d, input logic [4:0] rd);
    i_valid = 1'b1; i_is_load = ld; i_is_store = st;
    i_funct3 = f3; i_op0 = b; i_imm = imm; i_op1 = d; i_rd = rd;
  endtask

  initial begin
    aresetn = 1'b0; i_flush = 1'b0; idle();
    i_funct3 = '0; i_imm = '0; i_op0 = '0; i_op1 = '0; i_rd = '0;
    i_req_ready = 1'b1; i_rsp_valid = 1'b0; i_rsp_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", o_req_valid, 0);
    chk("rst_wb_valid", o_wb_valid, 0);
    chk("rst_cnt", o_lq_cnt, 0);
    chk("rst_ready", o_ready, 1);
    aresetn = 1'b1;

    // SB at 0x1003
    @(negedge clk);
    drv(0, 1, 3'b000, 32'h1000, 12'h003, 32'hAABBCCDD, 0);
    #1 chk("sb_ready", o_ready, 1);
    @(negedge clk); idle();
    #1;
    chk("sb_valid", o_req_valid, 1);
    chk("sb_cmd", o_req_cmd, 1);
    chk("sb_addr", o_req_addr, 32'h1003);
    chk("sb_size", o_req_size, 0);
    chk("sb_strb", o_req_strb, 4'b1000);
    chk("sb_data", o_req_data, 32'hDD000000);
    @(negedge clk);
    #1 chk("sb_done", o_req_valid, 0);

    // instruction with neither flag
    @(negedge clk); drv(0, 0, 3'b010, 32'h1000, 12'h000, 0, 3);
    @(negedge clk); idle();
    #1 chk("nop_noreq", o_req_valid, 0);

    // SH with negative immediate
    @(negedge clk);
    drv(0, 1, 3'b001, 32'h2000, 12'hFFE, 32'h12345678, 0);
    @(negedge clk); idle();
    #1;
    chk("sh_addr", o_req_addr, 32'h1FFE);
    chk("sh_size", o_req_size, 1);
    chk("sh_strb", o_req_strb, 4'b1100);
    chk("sh_data", o_req_data, 32'h56780000);
    @(negedge clk);

    // LB then LBU at 0x2002
    @(negedge clk); drv(1, 0, 3'b000, 32'h2000, 12'h002, 0, 5);
    @(negedge clk); drv(1, 0, 3'b100, 32'h2000, 12'h002, 0, 6);
    @(negedge clk); idle();
    #1;
    chk("lb_cnt1", o_lq_cnt, 1);
    chk("lbu_req", o_req_valid, 1);
    chk("lbu_cmd", o_req_cmd, 0);
    chk("lbu_addr", o_req_addr, 32'h2002);
    @(negedge clk);
    #1 chk("lb_cnt2", o_lq_cnt, 2);
    i_rsp_valid = 1'b1; i_rsp_data = 32'h00800000;
    @(negedge clk);
    #1;
    chk("lb_wbv", o_wb_valid, 1);
    chk("lb_rd", o_wb_rd, 5);
    chk("lb_data", o_wb_data, 32'hFFFFFF80);
    @(negedge clk); i_rsp_valid = 1'b0;
    #1;
    chk("lbu_wbv", o_wb_valid, 1);
    chk("lbu_rd", o_wb_rd, 6);
    chk("lbu_data", o_wb_data, 32'h00000080);
    chk("lbu_cnt0", o_lq_cnt, 0);
    @(negedge clk);
    #1 chk("wb_pulse", o_wb_valid, 0);

    // fill the load queue
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv(1, 0, 3'b010, 32'h3000, 12'(4 * i), 0, 5'(i + 1));
      #1 chk("fill_ready", o_ready, 1);
    end
    @(negedge clk); drv(1, 0, 3'b010, 32'h3000, 12'h010, 0, 5);
    #1 chk("full_pend_ready", o_ready, 0);
    @(negedge clk);
    #1;
    chk("full_cnt", o_lq_cnt, 4);
    chk("full_ready", o_ready, 0);
    chk("full_noreq", o_req_valid, 0);
    i_rsp_valid = 1'b1; i_rsp_data = 32'h11111111;
    @(negedge clk); i_rsp_valid = 1'b0;
    #1;
    chk("pop1_rd", o_wb_rd, 1);
    chk("pop1_data", o_wb_data, 32'h11111111);
    chk("pop1_cnt", o_lq_cnt, 3);
    chk("pop1_ready", o_ready, 1);
    @(negedge clk);
    #1;
    chk("l5_req", o_req_valid, 1);
    chk("l5_cnt", o_lq_cnt, 3);
    idle(); i_rsp_valid = 1'b1; i_rsp_data = 32'h22222222;
    @(negedge clk); i_rsp_valid = 1'b0;
    #1;
    chk("simul_rd", o_wb_rd, 2);
    chk("simul_data", o_wb_data, 32'h22222222);
    chk("simul_cnt", o_lq_cnt, 3);

    // flush with 3 queued loads and a stalled request
    i_req_ready = 1'b0;
    drv(1, 0, 3'b010, 32'h4000, 12'h000, 0, 7);
    #1 chk("stall_acc_ready", o_ready, 1);
    @(negedge clk); idle();
    #1;
    chk("stall_req", o_req_valid, 1);
    chk("stall_addr", o_req_addr, 32'h4000);
    chk("stall_ready", o_ready, 0);
    @(negedge clk);
    #1 chk("stall_hold", o_req_valid, 1);
    i_flush = 1'b1;
    #1 chk("flush_ready", o_ready, 0);
    @(negedge clk); i_flush = 1'b0; i_req_ready = 1'b1;
    #1;
    chk("flush_drop", o_req_valid, 0);
    chk("flush_cnt", o_lq_cnt, 3);
    i_rsp_valid = 1'b1; i_rsp_data = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("flush_nowb", o_wb_valid, 0);
    end
    i_rsp_valid = 1'b0;
    chk("flush_cnt0", o_lq_cnt, 0);

    // LW at 0x1002
    @(negedge clk); drv(1, 0, 3'b010, 32'h1000, 12'h002, 0, 9);
    @(negedge clk); idle();
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_noreq", o_req_valid, 0);
    chk("mis_flag", o_misalign, 1);
    chk("mis_addr", o_misalign_addr, 32'h1002);
    chk("mis_st", o_misalign_st, 0);
    @(negedge clk);
    #1;
    chk("mis_pulse", o_misalign, 0);
    chk("mis_cnt", o_lq_cnt, 0);
`else
    chk("mis_req", o_req_valid, 1);
    chk("mis_addr", o_req_addr, 32'h1002);
    chk("mis_size", o_req_size, 2);
    chk("mis_strb", o_req_strb, 4'b1100);
    @(negedge clk);
    #1 chk("mis_cnt", o_lq_cnt, 1);
    i_rsp_valid = 1'b1; i_rsp_data = 32'hAABBCCDD;
    @(negedge clk); i_rsp_valid = 1'b0;
    #1;
    chk("mis_wbv", o_wb_valid, 1);
    chk("mis_rd", o_wb_rd, 9);
    chk("mis_data", o_wb_data, 32'h0000AABB);
`endif

    // reset with 2 loads outstanding
    @(negedge clk); drv(1, 0, 3'b010, 32'h5000, 12'h000, 0, 10);
    @(negedge clk); drv(1, 0, 3'b010, 32'h5000, 12'h004, 0, 11);
    @(negedge clk); idle();
    @(negedge clk);
    #1 chk("pre_rst_cnt", o_lq_cnt, 2);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_req", o_req_valid, 0);
    chk("mid_rst_addr", o_req_addr, 0);
    chk("mid_rst_strb", o_req_strb, 0);
    chk("mid_rst_wb", o_wb_valid, 0);
    chk("mid_rst_cnt", o_lq_cnt, 0);
    @(negedge clk); aresetn = 1'b1;
    i_rsp_valid = 1'b1; i_rsp_data = 32'h44444444;
    @(negedge clk); i_rsp_valid = 1'b0;
    #1;
    chk("late_rsp_wb", o_wb_valid, 0);
    chk("late_rsp_cnt", o_lq_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
